// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared LSTM sequencer encodings, default parameters and width helper
// Purpose: FSM state encoding for the H/C address sequencer, its default
//          parameter values and a counter-width helper.
// Ports:   none (package).
package lstm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_TIMESTEP   = 7;
  localparam int DEF_NUM_CELL   = 53;
  localparam int DEF_DELAY      = 5;
  localparam int DEF_BASE_H     = 0;
  localparam int DEF_BASE_C     = 0;

  // Width needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addr_gen_hc_seq_if.sv
// rtl/addr_gen_hc_seq_if.sv - control and address bus of the H/C address sequencer
// Purpose: bundles the sequencer control inputs and address/status outputs.
// Signals: start, clear, mode, stall        - control (master -> slave)
//          o_addr_h/o_valid_h, o_addr_c/o_valid_c - H and C read addresses
//          o_busy, o_done                   - status (slave -> master)
interface addr_gen_hc_seq_if
  import lstm_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  start;
  logic                  clear;
  logic                  mode;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] o_addr_h;
  logic [ADDR_WIDTH-1:0] o_addr_c;
  logic                  o_valid_h;
  logic                  o_valid_c;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output start, clear, mode, stall,
    input  o_addr_h, o_addr_c, o_valid_h, o_valid_c, o_busy, o_done
  );

  modport slave (
    input  start, clear, mode, stall,
    output o_addr_h, o_addr_c, o_valid_h, o_valid_c, o_busy, o_done
  );

endinterface

// File: rtl/addr_gen_hc_seq_wrap_cnt.sv
// rtl/addr_gen_hc_seq_wrap_cnt.sv - wrapping counter used for the k, r and t indices
// Purpose: counts 0..LIMIT-1 and wraps to 0.
// Ports:   clk, rst (async active-low), en (advance), clr (sync zero, wins over en),
//          q (count), q_inc (value taken on the next enabled edge), wrap (q at LIMIT-1).
module wrap_cnt #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_inc,
  output logic             wrap
);

  assign wrap  = (q == WIDTH'(LIMIT - 1));
  assign q_inc = wrap ? '0 : q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q_inc;
    end
  end

endmodule

// File: rtl/addr_gen_hc_seq.sv
// rtl/addr_gen_hc_seq.sv - H/C memory read-address sequencer for LSTM timesteps
// Purpose: for each timestep slot and each row r, bursts NUM_CELL H addresses,
//          then issues the row's C address on the first of DELAY gap cycles.
// Ports:   clk, rst (async active-low), bus (slave side of addr_gen_hc_seq_if).
module addr_gen_hc_seq
  import lstm_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMESTEP   = DEF_TIMESTEP,
  parameter int NUM_CELL   = DEF_NUM_CELL,
  parameter int DELAY      = DEF_DELAY,
  parameter int BASE_H     = DEF_BASE_H,
  parameter int BASE_C     = DEF_BASE_C
) (
  input logic              clk,
  input logic              rst,
  addr_gen_hc_seq_if.slave bus
);

  localparam int KW = cnt_w(NUM_CELL);
  localparam int TW = cnt_w(TIMESTEP);
  localparam int GW = cnt_w(DELAY);
  localparam logic [GW-1:0] G_LAST = GW'(DELAY - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMESTEP - 1);

  seq_state_e state, nstate_adv, nstate;
  logic       mode_q, mode_p;

  logic [KW-1:0] k_q, k_inc, k_p;
  logic [KW-1:0] r_q, r_inc, r_p;
  logic [TW-1:0] t_q, t_inc, t_p, ts_p;
  logic          k_wrap, r_wrap, t_wrap;
  logic [GW-1:0] g_q;
  logic          g_last;

  logic frz, launch, cnt_clr, k_en, g_en, r_en, t_en;

  logic [ADDR_WIDTH-1:0] addr_h_q, addr_c_q, addr_h_d, addr_c_d;
  logic                  valid_h_q, valid_c_q, busy_q, done_q;
  logic                  valid_h_d, valid_c_d, busy_d, done_d;

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input int base,
                                                      input logic [TW-1:0] ts,
                                                      input logic [KW-1:0] idx);
    return ADDR_WIDTH'(base) + ADDR_WIDTH'(ts) * ADDR_WIDTH'(NUM_CELL) + ADDR_WIDTH'(idx);
  endfunction

  // Stall only freezes the active states; IDLE and DONE keep moving.
  assign frz     = bus.stall && ((state == ST_BURST) || (state == ST_GAP));
  assign launch  = (state == ST_IDLE) && bus.start && !bus.clear;
  assign cnt_clr = bus.clear || launch;
  assign g_last  = (g_q == G_LAST);

  assign k_en = !bus.clear && !frz && (state == ST_BURST);
  assign g_en = !bus.clear && !frz && (state == ST_GAP);
  assign r_en = g_en && g_last;
  assign t_en = r_en && r_wrap;

  wrap_cnt #(.WIDTH(KW), .LIMIT(NUM_CELL)) u_k_cnt (
    .clk(clk), .rst(rst), .en(k_en), .clr(cnt_clr), .q(k_q), .q_inc(k_inc), .wrap(k_wrap)
  );

  wrap_cnt #(.WIDTH(KW), .LIMIT(NUM_CELL)) u_r_cnt (
    .clk(clk), .rst(rst), .en(r_en), .clr(cnt_clr), .q(r_q), .q_inc(r_inc), .wrap(r_wrap)
  );

  wrap_cnt #(.WIDTH(TW), .LIMIT(TIMESTEP)) u_t_cnt (
    .clk(clk), .rst(rst), .en(t_en), .clr(cnt_clr), .q(t_q), .q_inc(t_inc), .wrap(t_wrap)
  );

  // Gap-cycle counter: only its terminal value matters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_q <= '0;
    end else if (cnt_clr) begin
      g_q <= '0;
    end else if (g_en) begin
      g_q <= g_last ? '0 : g_q + 1'b1;
    end
  end

  // State register and mode latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      mode_q <= 1'b0;
    end else begin
      state <= nstate;
      if (launch) begin
        mode_q <= bus.mode;
      end
    end
  end

  // Next state; nstate_adv is where the sequence would go if not stalled.
  always_comb begin
    nstate_adv = state;
    case (state)
      ST_IDLE:  if (bus.start) nstate_adv = ST_BURST;
      ST_BURST: if (k_wrap) nstate_adv = ST_GAP;
      ST_GAP:   if (g_last) nstate_adv = (r_wrap && t_wrap) ? ST_DONE : ST_BURST;
      ST_DONE:  nstate_adv = ST_IDLE;
      default:  nstate_adv = ST_IDLE;
    endcase
    nstate = bus.clear ? ST_IDLE : (frz ? state : nstate_adv);
  end

  // Pending beat: the indices the outputs present after this edge. Under
  // stall the pending beat is presented with valids low and re-presented
  // with valids once the stall releases, so no beat is lost or duplicated.
  assign k_p    = launch ? '0 : ((state == ST_BURST) ? k_inc : k_q);
  assign r_p    = launch ? '0 : (((state == ST_GAP) && g_last) ? r_inc : r_q);
  assign t_p    = launch ? '0 : (((state == ST_GAP) && g_last && r_wrap) ? t_inc : t_q);
  assign mode_p = (state == ST_IDLE) ? bus.mode : mode_q;
  assign ts_p   = mode_p ? (T_LAST - t_p) : t_p;

  // Output values loaded at the coming edge.
  always_comb begin
    addr_h_d  = addr_h_q;
    addr_c_d  = addr_c_q;
    valid_h_d = 1'b0;
    valid_c_d = 1'b0;
    done_d    = 1'b0;
    busy_d    = (nstate != ST_IDLE);
    if (!bus.clear) begin
      case (nstate_adv)
        ST_BURST: begin
          addr_h_d  = slot_addr(BASE_H, ts_p, k_p);
          addr_c_d  = slot_addr(BASE_C, ts_p, r_p);
          valid_h_d = !frz;
        end
        ST_GAP:  valid_c_d = (state == ST_BURST) && !frz;
        ST_DONE: done_d    = !frz;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_h_q  <= '0;
      addr_c_q  <= '0;
      valid_h_q <= 1'b0;
      valid_c_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_h_q  <= addr_h_d;
      addr_c_q  <= addr_c_d;
      valid_h_q <= valid_h_d;
      valid_c_q <= valid_c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_addr_h  = addr_h_q;
  assign bus.o_addr_c  = addr_c_q;
  assign bus.o_valid_h = valid_h_q;
  assign bus.o_valid_c = valid_c_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;

endmodule

// File: tb/tb_addr_gen_hc_seq.sv
// tb/tb_addr_gen_hc_seq.sv - scoreboard bench for the H/C address sequencer
module tb_addr_gen_hc_seq;

  localparam int AW     = 12;
  localparam int T      = 2;
  localparam int N      = 3;
  localparam int D      = 2;
  localparam int BH     = 0;
  localparam int BC     = 16;
  localparam int EV_H   = 0;
  localparam int EV_C   = 1;
  localparam int EV_D   = 2;

  typedef struct {
    int kind;
    int a;
    int c;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  ev_t  sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  addr_gen_hc_seq_if #(.ADDR_WIDTH(AW)) bus ();

  addr_gen_hc_seq #(
    .ADDR_WIDTH(AW), .TIMESTEP(T), .NUM_CELL(N), .DELAY(D), .BASE_H(BH), .BASE_C(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic push_row(input int ts, input int r);
    for (int k = 0; k < N; k++) sb.push_back('{EV_H, BH + ts * N + k, BC + ts * N + r});
    sb.push_back('{EV_C, BC + ts * N + r, 0});
  endtask

  task automatic push_seq(input bit m);
    for (int t = 0; t < T; t++)
      for (int r = 0; r < N; r++) push_row(m ? (T - 1 - t) : t, r);
    sb.push_back('{EV_D, 0, 0});
  endtask

  // Every valid/done cycle consumes one expected event.
  always @(negedge clk) begin
    ev_t e;
    int  kind_obs, a_obs;
    if (rst && (bus.o_valid_h || bus.o_valid_c || bus.o_done)) begin
      kind_obs = bus.o_done ? EV_D : (bus.o_valid_c ? EV_C : EV_H);
      a_obs    = bus.o_done ? 0 : (bus.o_valid_c ? int'(bus.o_addr_c) : int'(bus.o_addr_h));
      if (sb.size() == 0) begin
        chk("sb_unexpected", kind_obs, -1);
      end else begin
        e = sb.pop_front();
        chk("sb_kind", kind_obs, e.kind);
        chk("sb_addr", a_obs, e.a);
        if (e.kind == EV_H) chk("sb_addr_c_hold", int'(bus.o_addr_c), e.c);
      end
    end
  end

  task automatic pulse_start(input bit m);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.mode  = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_seq(input string tag, input bit m, input int stall_at, input int stall_len,
                         input int stall_addr, input int poke_at, input int exp_cyc);
    int n;
    bit got_done;
    push_seq(m);
    pulse_start(m);
    n = 0;
    got_done = 1'b0;
    while (!got_done && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_busy"}, bus.o_busy, 1);
      if (stall_len > 0 && n > stall_at && n <= stall_at + stall_len) begin
        chk({tag, "_stall_vh"}, bus.o_valid_h, 0);
        chk({tag, "_stall_vc"}, bus.o_valid_c, 0);
        chk({tag, "_stall_addr"}, int'(bus.o_addr_h), stall_addr);
      end
      if (stall_len > 0 && n == stall_at) bus.stall = 1'b1;
      if (stall_len > 0 && n == stall_at + stall_len) bus.stall = 1'b0;
      if (n == poke_at) begin bus.start = 1'b1; bus.mode = ~m; end
      if (n == poke_at + 1) begin bus.start = 1'b0; bus.mode = m; end
      if (bus.o_done) got_done = 1'b1;
    end
    if (!got_done) chk({tag, "_timeout"}, 0, 1);
    else chk({tag, "_done_cyc"}, n, exp_cyc);
    @(negedge clk);
    chk({tag, "_idle"}, bus.o_busy, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.mode  = 1'b0;
    bus.stall = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_addr_h", int'(bus.o_addr_h), 0);
    chk("rst_addr_c", int'(bus.o_addr_c), 0);
    chk("rst_valid_h", bus.o_valid_h, 0);
    chk("rst_valid_c", bus.o_valid_c, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Forward and reverse timestep order: 30 active cycles then DONE.
    run_seq("fwd", 1'b0, -10, 0, 0, -10, 31);
    run_seq("bwd", 1'b1, -10, 0, 0, -10, 31);

    // Four stalled edges while k=1 is pending.
    run_seq("stall", 1'b0, 1, 4, 1, -10, 35);

    // Clear on the first gap cycle of t=1: IDLE next cycle, no DONE.
    for (int r = 0; r < N; r++) push_row(0, r);
    push_row(1, 0);
    pulse_start(1'b0);
    repeat (19) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("clr_busy", bus.o_busy, 0);
    chk("clr_valid_h", bus.o_valid_h, 0);
    chk("clr_valid_c", bus.o_valid_c, 0);
    chk("clr_done", bus.o_done, 0);
    repeat (4) @(negedge clk);
    chk("clr_still_idle", bus.o_busy, 0);
    chk("clr_sb_empty", sb.size(), 0);
    run_seq("restart", 1'b0, -10, 0, 0, -10, 31);

    // Start together with clear is ignored.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    @(negedge clk);
    chk("sc_busy", bus.o_busy, 0);
    chk("sc_valid_h", bus.o_valid_h, 0);

    // Start while busy (with the other mode) is ignored.
    run_seq("busy_start", 1'b1, -10, 0, 0, 10, 31);

    // Asynchronous reset mid-burst.
    push_seq(1'b0);
    pulse_start(1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_addr_h", int'(bus.o_addr_h), 0);
    chk("arst_addr_c", int'(bus.o_addr_c), 0);
    chk("arst_valid_h", bus.o_valid_h, 0);
    chk("arst_busy", bus.o_busy, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("arst_idle", bus.o_busy, 0);
    run_seq("post_rst", 1'b1, -10, 0, 0, -10, 31);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/addr_gen_hc_seq.md
ADDR_GEN_HC_SEQ -- requirements
Module: addr_gen_hc_seq

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, meaning the address bus width.
REQ-002 The block SHALL have parameter TIMESTEP, default 7, meaning the number of timesteps sequenced.
REQ-003 The block SHALL have parameter NUM_CELL, default 53, meaning both the burst length and the rows per timestep.
REQ-004 The block SHALL have parameter DELAY, default 5 (legal range 1 or more), meaning the gap cycles after each burst.
REQ-005 The block SHALL have parameter BASE_H, default 0, meaning the H memory base address.
REQ-006 The block SHALL have parameter BASE_C, default 0, meaning the C memory base address.
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock, all logic on the rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit, reset that is asynchronous and active-low.
REQ-009 The block SHALL have port start, input, 1 bit, which launches a sequence when idle.
REQ-010 The block SHALL have port clear, input, 1 bit, a synchronous abort.
REQ-011 The block SHALL have port mode, input, 1 bit: 0 gives ascending timestep order (forward), 1 gives descending order (BPTT replay); it is sampled on accepted start.
REQ-012 The block SHALL have port stall, input, 1 bit, which freezes sequencing.
REQ-013 The block SHALL have port o_addr_h, output, ADDR_WIDTH bits, the H read address.
REQ-014 The block SHALL have port o_addr_c, output, ADDR_WIDTH bits, the C read address.
REQ-015 The block SHALL have port o_valid_h, output, 1 bit, qualifying o_addr_h.
REQ-016 The block SHALL have port o_valid_c, output, 1 bit, qualifying o_addr_c.
REQ-017 The block SHALL have port o_busy, output, 1 bit, high while not IDLE.
REQ-018 The block SHALL have port o_done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have states IDLE, BURST, GAP and DONE, with all outputs registered.
REQ-020 In IDLE, start=1 (and clear=0) SHALL latch mode, zero the counters k, r and t, and enter BURST; the first valid address SHALL appear the cycle after start.
REQ-021 The timestep slot ts SHALL equal t when mode=0 and TIMESTEP-1-t when mode=1; slot 0 holds the zero initial state h(-1)/c(-1), so memory spans TIMESTEP+1 slots.
REQ-022 BURST SHALL last NUM_CELL cycles with o_valid_h=1, o_addr_h=BASE_H+ts*NUM_CELL+k (k=0..NUM_CELL-1), and o_addr_c=BASE_C+ts*NUM_CELL+r held constant.
REQ-023 GAP SHALL last DELAY cycles with o_valid_h=0 and o_addr_h holding its last value; o_valid_c SHALL be 1 on the first GAP cycle only, and o_addr_c SHALL stay unchanged.
REQ-024 At the end of GAP, r SHALL increment; when r wraps from NUM_CELL-1 to 0, t SHALL increment; after the GAP ending r=NUM_CELL-1 and t=TIMESTEP-1, the FSM SHALL enter DONE.
REQ-025 DONE SHALL assert o_done for one cycle and then return to IDLE; a total sequence SHALL be TIMESTEP*NUM_CELL*(NUM_CELL+DELAY) active cycles plus one DONE cycle.
REQ-026 stall=1 SHALL freeze state, counters and addresses and force o_valid_h=o_valid_c=0; on release, the frozen cycle SHALL be re-issued with its valids.
REQ-027 clear=1 in any state SHALL return the FSM to IDLE next cycle without an o_done pulse; clear SHALL win over start and over stall.
REQ-028 start while busy SHALL be ignored; start coincident with DONE SHALL be ignored.
REQ-029 Address arithmetic SHALL be unsigned modulo 2^ADDR_WIDTH; the integrator guarantees BASE+(TIMESTEP+1)*NUM_CELL <= 2^ADDR_WIDTH.

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, set all counters, o_addr_h and o_addr_c to 0, clear o_valid_h, o_valid_c, o_busy and o_done, and set the latched mode to 0.
REQ-031 Reset deassertion SHALL be synchronised externally; the first active edge after deassertion behaves as IDLE.

Structure
REQ-032 The FSM state encodings and default parameter constants SHALL reside in the shared LSTM package/include (lstm_pkg).
REQ-033 The k, r and t counters SHALL each be an instance of one sub-module, wrap_cnt (parametrised width/limit, inputs en and clr, output wrap flag).

Verification (TIMESTEP=2, NUM_CELL=3, DELAY=2, BASE_H=0, BASE_C=16 unless stated)
REQ-034 Scenario: start pulse with mode=0 -> o_addr_h 0,1,2 (valid), two gap cycles, with o_valid_c on the first gap at o_addr_c=16; rows continue at c=17, 18; t=1 gives h 3,4,5 and c 19..21; o_done on cycle 31.
REQ-035 Scenario: mode=1 -> the first burst is h 3,4,5 with c=19; the last burst is h 0,1,2 with c=18; the total is still 30 active cycles plus DONE.
REQ-036 Scenario: stall for 4 cycles mid-burst at k=1 -> valids low, addresses frozen at h=1; after release, h=1,2 is issued and completion is 4 cycles later.
REQ-037 Scenario: clear during GAP of t=1 -> IDLE next cycle, no o_done; a fresh start then restarts at h=0 and c=16.
REQ-038 Scenario: start while busy, and start with clear simultaneously -> both ignored; the sequence timing is unchanged.
REQ-039 Scenario: rst low mid-BURST -> all outputs 0 immediately (asynchronously), IDLE after release.
